// File: rtl/task_stream_master.sv
// task_stream_master
//   Master-side driver for a task. It takes a packet of signed samples from
//   upstream and sends each one low byte first on the task byte bus. It then
//   collects the task's 32-bit answer words into a one-deep output register
//   and checks the total answer length against the size the task reports.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_s_* / o_s_ready       upstream sample stream (valid/ready, last)
//   o_tdata*, i_tready      task byte bus (valid/request, last)
//   i_tanswer_*, i_packet_size_in_bytes, o_tmanager_ready
//                           answer words from the task and reported size
//   o_ans_*, i_ans_ready    answer words to downstream (valid/ready, last)
//   o_busy                  high whenever the FSM is not idle
//   o_size_err              sticky length-mismatch flag, cleared at packet start
//   o_timeout               one-cycle answer watchdog pulse
//
// Configuration
//   TASK_STREAM_MASTER_TIMEOUT_EN  enables the answer watchdog. When it is
//   undefined, o_timeout is tied to 0 and WAIT_ANS waits indefinitely.
//
// States
//   IDLE     | ready for the first sample of a packet
//   SEND     | driving the bytes of the latched sample
//   FETCH    | last byte sent, waiting for the next sample of the packet
//   WAIT_ANS | accepting answer words from the task
//   DRAIN    | final answer word held, waiting for downstream to take it
module task_stream_master #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int MAX_SAMPLES    = 50,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_s_valid,
  input  logic [SAMPLE_WIDTH-1:0] i_s_data,
  input  logic                    i_s_last,
  output logic                    o_s_ready,
  output logic [7:0]              o_tdata,
  output logic                    o_tdata_valid,
  output logic                    o_tdata_last,
  input  logic                    i_tready,
  input  logic                    i_tanswer_ready,
  input  logic [31:0]             i_tanswer_data,
  input  logic                    i_tanswer_data_last,
  input  logic [11:0]             i_packet_size_in_bytes,
  output logic                    o_tmanager_ready,
  output logic                    o_ans_valid,
  output logic [31:0]             o_ans_data,
  output logic                    o_ans_last,
  input  logic                    i_ans_ready,
  output logic                    o_busy,
  output logic                    o_size_err,
  output logic                    o_timeout
);

  localparam int BYTES = SAMPLE_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = $clog2(MAX_SAMPLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_FETCH,
    ST_WAIT_ANS,
    ST_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    last_q, last_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        scnt_q, scnt_d;
  logic [11:0]             bcnt_q, bcnt_d;
  logic                    size_err_q, size_err_d;
  logic                    ans_valid_q, ans_valid_d;
  logic [31:0]             ans_data_q, ans_data_d;
  logic                    ans_last_q, ans_last_d;

`ifdef TASK_STREAM_MASTER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  logic       forced_last;
  logic       pkt_last;
  logic       on_last_byte;
  logic       byte_xfer;
  logic       s_ready;
  logic       s_xfer;
  logic       tm_ready;
  logic       a_xfer;
  logic       d_xfer;
  logic [11:0] bcnt_inc;
  logic [7:0]  byte_sel;

  // The sample that fills the packet to MAX_SAMPLES closes it even without i_s_last.
  assign forced_last  = (scnt_q == CNT_W'(MAX_SAMPLES));
  assign pkt_last     = last_q | forced_last;
  assign on_last_byte = (idx_q == IDX_LAST);
  assign byte_xfer    = (state_q == ST_SEND) & i_tready;

  always_comb begin
    byte_sel = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (idx_q == IDX_W'(b)) byte_sel = sample_q[8*b +: 8];
    end
  end

  // The next sample is fetched in the same cycle as the final byte of the
  // current one, so back-to-back samples stream without a gap.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_FETCH: s_ready = 1'b1;
      ST_SEND:           s_ready = byte_xfer & on_last_byte & ~pkt_last;
      default:           s_ready = 1'b0;
    endcase
    s_ready = s_ready & ~i_rst;
  end

  assign s_xfer   = s_ready & i_s_valid;
  assign tm_ready = (state_q == ST_WAIT_ANS) & (~ans_valid_q | i_ans_ready) & ~i_rst;
  assign a_xfer   = tm_ready & i_tanswer_ready;
  assign d_xfer   = ans_valid_q & i_ans_ready;
  assign bcnt_inc = (bcnt_q > 12'd4091) ? 12'hFFF : bcnt_q + 12'd4;

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    last_d      = last_q;
    idx_d       = idx_q;
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    size_err_d  = size_err_q;
    ans_valid_d = ans_valid_q;
    ans_data_d  = ans_data_q;
    ans_last_d  = ans_last_q;
`ifdef TASK_STREAM_MASTER_TIMEOUT_EN
    wd_d        = wd_q;
    timeout_d   = 1'b0;
`endif

    // Load and drain can happen in the same cycle, so the register never bubbles.
    if (a_xfer) begin
      ans_valid_d = 1'b1;
      ans_data_d  = i_tanswer_data;
      ans_last_d  = i_tanswer_data_last;
    end else if (d_xfer) begin
      ans_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_xfer) begin
          sample_d   = i_s_data;
          last_d     = i_s_last;
          idx_d      = '0;
          scnt_d     = CNT_W'(1);
          bcnt_d     = '0;
          size_err_d = 1'b0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (byte_xfer) begin
          if (!on_last_byte) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (pkt_last) begin
            if (forced_last && !last_q) size_err_d = 1'b1;
            state_d = ST_WAIT_ANS;
`ifdef TASK_STREAM_MASTER_TIMEOUT_EN
            wd_d    = WD_LOAD;
`endif
          end else if (s_xfer) begin
            sample_d = i_s_data;
            last_d   = i_s_last;
            idx_d    = '0;
            scnt_d   = scnt_q + CNT_W'(1);
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (s_xfer) begin
          sample_d = i_s_data;
          last_d   = i_s_last;
          idx_d    = '0;
          scnt_d   = scnt_q + CNT_W'(1);
          state_d  = ST_SEND;
        end
      end
      ST_WAIT_ANS: begin
        if (a_xfer) begin
          bcnt_d = bcnt_inc;
          if (i_tanswer_data_last) begin
            size_err_d = size_err_q | (bcnt_inc != i_packet_size_in_bytes);
            state_d    = ST_DRAIN;
          end
`ifdef TASK_STREAM_MASTER_TIMEOUT_EN
          wd_d = WD_LOAD;
        end else if (wd_q == '0) begin
          timeout_d   = 1'b1;
          size_err_d  = 1'b1;
          ans_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          wd_d = wd_q - WD_W'(1);
`endif
        end
      end
      ST_DRAIN: begin
        if (!ans_valid_q || d_xfer) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      sample_q    <= '0;
      last_q      <= 1'b0;
      idx_q       <= '0;
      scnt_q      <= '0;
      bcnt_q      <= '0;
      size_err_q  <= 1'b0;
      ans_valid_q <= 1'b0;
      ans_data_q  <= '0;
      ans_last_q  <= 1'b0;
`ifdef TASK_STREAM_MASTER_TIMEOUT_EN
      wd_q        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      scnt_q      <= scnt_d;
      bcnt_q      <= bcnt_d;
      size_err_q  <= size_err_d;
      ans_valid_q <= ans_valid_d;
      ans_data_q  <= ans_data_d;
      ans_last_q  <= ans_last_d;
`ifdef TASK_STREAM_MASTER_TIMEOUT_EN
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign o_s_ready        = s_ready;
  assign o_tdata_valid    = (state_q == ST_SEND);
  assign o_tdata          = (state_q == ST_SEND) ? byte_sel : 8'h00;
  assign o_tdata_last     = (state_q == ST_SEND) & on_last_byte & pkt_last;
  assign o_tmanager_ready = tm_ready;
  assign o_ans_valid      = ans_valid_q;
  assign o_ans_data       = ans_data_q;
  assign o_ans_last       = ans_last_q;
  assign o_busy           = (state_q != ST_IDLE);
  assign o_size_err       = size_err_q;
`ifdef TASK_STREAM_MASTER_TIMEOUT_EN
  assign o_timeout        = timeout_q;
`else
  assign o_timeout        = 1'b0;
`endif

endmodule

// File: doc/task_stream_master.md
Name: task_stream_master

Overview:
- Master-side counterpart of the task slave wrappers. Drives a task's input byte interface and consumes its 32-bit answer interface.
- Upstream supplies a packet of signed samples. The block serializes them low-byte-first onto the task data bus, honouring the task's data request. It then collects answer words into a one-deep output register, checking the answer length against the reported packet size.
- Used as the task-manager model in per-task benches and as the on-chip driver in the task test harness.

Parameters:
SAMPLE_WIDTH, 16, upstream sample width; multiple of 8; BYTES = SAMPLE_WIDTH/8
MAX_SAMPLES, 50, max samples per packet; sizes the sample counter
TIMEOUT_CYCLES, 1024, answer watchdog limit (optional feature only)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous and active-high
i_s_valid  in  1  upstream sample valid
i_s_data  in  SAMPLE_WIDTH  upstream sample
i_s_last  in  1  final sample of packet
o_s_ready  out  1  sample accepted when high with i_s_valid
o_tdata  out  8  task data byte
o_tdata_valid  out  1  byte valid
o_tdata_last  out  1  final byte of packet
i_tready  in  1  task data request
i_tanswer_ready  in  1  answer word valid from task
i_tanswer_data  in  32  answer word
i_tanswer_data_last  in  1  final answer word
i_packet_size_in_bytes  in  12  answer size reported by task
o_tmanager_ready  out  1  manager ready for answer word
o_ans_valid  out  1  answer word to downstream valid
o_ans_data  out  32  answer word
o_ans_last  out  1  final answer word
i_ans_ready  in  1  downstream accepts
o_busy  out  1  high whenever state != IDLE
o_size_err  out  1  sticky length mismatch flag
o_timeout  out  1  one-cycle watchdog pulse

Behaviour:
- Reset state: IDLE. All outputs 0. Counters and registers cleared.
- Reset mid-packet aborts everything: partial byte stream and any held answer word are discarded.
- Handshakes:
  - Byte transfer occurs on a cycle with o_tdata_valid && i_tready.
  - Answer transfer occurs on a cycle with i_tanswer_ready && o_tmanager_ready.
  - Downstream transfer occurs on a cycle with o_ans_valid && i_ans_ready.
  - o_tdata, o_tdata_last and o_tdata_valid are registered and stay stable while valid is high and i_tready is low.
- States:
  - IDLE:
    - o_s_ready = 1.
    - On an upstream sample transfer: latch sample and last flag, byte index := 0, clear o_size_err, go to SEND.
  - SEND:
    - o_tdata = latched sample byte[index], low byte first. o_tdata_valid = 1.
    - o_tdata_last = latched last && index == BYTES-1.
    - On a byte transfer, if index < BYTES-1: index += 1.
    - On a byte transfer with index == BYTES-1:
      - If latched last: go to WAIT_ANS.
      - Otherwise: o_s_ready pulses to fetch the next sample. When it is accepted, index := 0 and stay in SEND. If no sample is valid, go to FETCH.
  - FETCH:
    - o_s_ready = 1, o_tdata_valid = 0.
    - On a sample transfer: latch and return to SEND.
  - WAIT_ANS / RECV:
    - o_tmanager_ready = !o_ans_valid || i_ans_ready.
    - Each accepted answer word loads the output register and adds 4 to the byte counter (12-bit, saturating at 4095).
    - If the accepted word has i_tanswer_data_last: o_size_err := (counter+4 != i_packet_size_in_bytes), then go to DRAIN.
  - DRAIN: go to IDLE once the output register empties.
- Sample counter: reaching MAX_SAMPLES without i_s_last forces o_tdata_last on the final byte of that sample, and sets o_size_err.
- Answer word arriving while in SEND or FETCH: not accepted (o_tmanager_ready = 0).
- Simultaneous downstream drain and new answer word: both occur in the same cycle; no bubble.
- Latency:
  - First byte valid 1 cycle after the sample transfer.
  - Answer word valid at o_ans_* 1 cycle after acceptance.

Optional Feature:
- TASK_STREAM_MASTER_TIMEOUT_EN defined:
  - Watchdog counts cycles in WAIT_ANS with no answer word accepted; the count resets on each accepted word.
  - At TIMEOUT_CYCLES: o_timeout pulses one cycle, o_size_err is set, held answer is discarded, state goes to IDLE.
- Not defined: o_timeout tied 0; WAIT_ANS waits indefinitely.

Test Plan:
- Samples 0x1234, 0xABCD (last), i_tready=1 -> bytes 34,12,CD,AB on 4 consecutive cycles; last only with AB; o_busy high throughout.
- Same packet, i_tready toggling 1,0,1,0 -> each byte held stable while stalled; 4 transfers total; order unchanged.
- Answers 0x00000001, 0x00000002 (last), i_packet_size_in_bytes=8, i_ans_ready=1 -> both words out in order; o_ans_last on the second; o_size_err=0; IDLE after drain.
- Same answers with i_packet_size_in_bytes=12 -> o_size_err=1 after last word; cleared at start of next packet.
- i_ans_ready=0 for 5 cycles during answers -> o_tmanager_ready low after the first word; no word lost or duplicated.
- i_rst asserted mid-SEND after byte 2 -> all outputs 0 next cycle; a new packet afterwards is sent correctly. With the macro defined and no answer for 1024 cycles, o_timeout pulses once.
